div_seq: RTL

Parametrised sequential integer divider for the RV32M/RV64M DIV, DIVU, REM and REMU operations, sitting in the execute stage beside the ALU. It replaces the fixed 32-bit, 1-bit/cycle divider with the following additions:
- configurable width and radix (quotient bits per cycle);
- a full valid/ready handshake on both sides, with operands and opcode latched at accept;
- RISC-V-exact divide-by-zero and signed-overflow results;
- a one-cycle early-out for those special cases;
- a synchronous flush for pipeline kills.

---
 rtl/div_pkg.sv | 20 ++
 rtl/div_step.sv | 22 ++
 rtl/div_seq.sv | 126 ++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared types, func3 encodings and iteration helper for the sequential divider
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [2:0] DIV  = 3'b100;
    localparam logic [2:0] DIVU = 3'b101;
    localparam logic [2:0] REM  = 3'b110;
    localparam logic [2:0] REMU = 3'b111;

    function automatic int div_iters(input int xlen, input int bits_per_cycle);
        return xlen / bits_per_cycle;
    endfunction

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational restoring division step on the {rem, quot} pair
module div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rem_in,
    input  logic [XLEN-1:0] quot_in,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] rem_out,
    output logic [XLEN-1:0] quot_out
);

    logic [XLEN:0] partial;
    logic [XLEN:0] diff;

    assign partial = {rem_in, quot_in[XLEN-1]};
    assign diff    = partial - {1'b0, divisor};

    // On a failed trial the partial is below the divisor, so it always fits in XLEN bits.
    assign rem_out  = diff[XLEN] ? partial[XLEN-1:0] : diff[XLEN-1:0];
    assign quot_out = {quot_in[XLEN-2:0], ~diff[XLEN]};

endmodule

// File: rtl/div_seq.sv
// rtl/div_seq.sv - radix-configurable sequential RV32M/RV64M divider with valid/ready handshake
module div_seq
    import div_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] op1,
    input  logic [XLEN-1:0] op2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_data
);

    localparam int N  = div_iters(XLEN, BITS_PER_CYCLE);
    localparam int CW = $clog2(N) + 1;
    localparam logic [CW-1:0]   CNT_LOAD = CW'(N - 1);
    localparam logic [XLEN-1:0] SMIN     = {1'b1, {(XLEN-1){1'b0}}};

    state_t          state, state_next;
    logic [CW-1:0]   cnt;
    logic [XLEN-1:0] rem, quot, dvsr;
    logic            rem_sel, neg_q, neg_r;

    logic            accept, sgn1, sgn2, div_zero, ovf, special;
    logic [XLEN-1:0] mag1, mag2, special_data, q_fix, r_fix;
    logic            unused_op_bit;

    assign unused_op_bit = op[2];

    assign accept   = in_valid && (state == IDLE) && !flush;
    assign sgn1     = !op[0] && op1[XLEN-1];
    assign sgn2     = !op[0] && op2[XLEN-1];
    assign mag1     = sgn1 ? -op1 : op1;
    assign mag2     = sgn2 ? -op2 : op2;
    assign div_zero = (op2 == '0);
    assign ovf      = !op[0] && (op1 == SMIN) && (op2 == '1);
    assign special  = div_zero || ovf;

    always_comb begin
        special_data = '0;
        if (div_zero)
            special_data = op[1] ? op1 : '1;
        else
            special_data = op[1] ? '0 : op1;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = special ? DONE : BUSY;
            BUSY:    if (cnt == '0) state_next = FIX;
            FIX:     state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (flush)
            state_next = IDLE;
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    logic [XLEN-1:0] rem_chain  [BITS_PER_CYCLE+1];
    logic [XLEN-1:0] quot_chain [BITS_PER_CYCLE+1];

    assign rem_chain[0]  = rem;
    assign quot_chain[0] = quot;

    for (genvar i = 0; i < BITS_PER_CYCLE; i++) begin : g_step
        div_step #(.XLEN(XLEN)) u_step (
            .rem_in   (rem_chain[i]),
            .quot_in  (quot_chain[i]),
            .divisor  (dvsr),
            .rem_out  (rem_chain[i+1]),
            .quot_out (quot_chain[i+1])
        );
    end

    assign q_fix = neg_q ? -quot : quot;
    assign r_fix = neg_r ? -rem  : rem;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt      <= '0;
            rem      <= '0;
            quot     <= '0;
            dvsr     <= '0;
            rem_sel  <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            out_data <= '0;
        end else if (accept) begin
            cnt     <= CNT_LOAD;
            rem     <= '0;
            quot    <= mag1;
            dvsr    <= mag2;
            rem_sel <= op[1];
            neg_q   <= sgn1 ^ sgn2;
            neg_r   <= sgn1;
            if (special)
                out_data <= special_data;
        end else if (!flush && state == BUSY) begin
            rem  <= rem_chain[BITS_PER_CYCLE];
            quot <= quot_chain[BITS_PER_CYCLE];
            if (cnt != '0)
                cnt <= cnt - 1'b1;
        end else if (!flush && state == FIX) begin
            out_data <= rem_sel ? r_fix : q_fix;
        end
    end

endmodule
